// File: rtl/morse_tone_player.sv
// Morse pattern player: serialises a latched on/off unit pattern (LSB first) at a
// programmable unit rate and gates a square-wave tone onto beep, with repeat and abort.
module morse_tone_player #(
    parameter int PATTERN_W = 75,
    parameter int TONE_DIV  = 2000,
    parameter int UNIT_DIV  = 382000,
    parameter int GAP_UNITS = 7,
    parameter int LEN_W     = $clog2(PATTERN_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [LEN_W-1:0]     length,
    input  logic                 repeat_en,
    input  logic                 stop,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     bit_idx,
    output logic                 beep
);

    localparam int UNIT_W = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int GAP_W  = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;

    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(PATTERN_W);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_e;

    state_e                 state_q, state_d;
    logic [PATTERN_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       bit_idx_q, bit_idx_d;
    logic [UNIT_W-1:0]      unit_cnt_q, unit_cnt_d;
    logic [TONE_W-1:0]      tone_cnt_q, tone_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   tone_q, tone_d;
    logic                   done_q, done_d;

    logic [LEN_W-1:0]       eff_len;
    logic                   unit_end;
    logic                   last_unit;
    logic                   restart;
    logic                   to_idle;
    logic                   pat_bit;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        bit_idx_d  = bit_idx_q;
        unit_cnt_d = unit_cnt_q;
        tone_cnt_d = tone_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tone_d     = tone_q;
        done_d     = 1'b0;
        restart    = 1'b0;
        to_idle    = 1'b0;

        eff_len   = (length > MAX_LEN) ? MAX_LEN : length;
        unit_end  = (unit_cnt_q == UNIT_LAST);
        last_unit = ((bit_idx_q + LEN_W'(1)) == len_q);

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (eff_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        pat_d   = pattern;
                        len_d   = eff_len;
                        restart = 1'b1;
                    end
                end
            end

            PLAY: begin
                if (stop) begin
                    to_idle = 1'b1;
                end else begin
                    if (tone_cnt_q == TONE_LAST) begin
                        tone_cnt_d = '0;
                        tone_d     = ~tone_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + TONE_W'(1);
                    end

                    if (!unit_end) begin
                        unit_cnt_d = unit_cnt_q + UNIT_W'(1);
                    end else if (!last_unit) begin
                        unit_cnt_d = '0;
                        bit_idx_d  = bit_idx_q + LEN_W'(1);
                    end else if (repeat_en && GAP_UNITS > 0) begin
                        state_d    = GAP;
                        unit_cnt_d = '0;
                        gap_cnt_d  = '0;
                        bit_idx_d  = '0;
                    end else if (repeat_en) begin
                        restart = 1'b1;
                    end else begin
                        to_idle = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end

            GAP: begin
                // The gap is GAP_UNITS whole units, counted as units x unit cycles.
                if (stop) begin
                    to_idle = 1'b1;
                end else if (!unit_end) begin
                    unit_cnt_d = unit_cnt_q + UNIT_W'(1);
                end else if (gap_cnt_q != GAP_LAST) begin
                    unit_cnt_d = '0;
                    gap_cnt_d  = gap_cnt_q + GAP_W'(1);
                end else if (repeat_en) begin
                    restart = 1'b1;
                end else begin
                    to_idle = 1'b1;
                    done_d  = 1'b1;
                end
            end

            default: to_idle = 1'b1;
        endcase

        if (restart) begin
            state_d    = PLAY;
            bit_idx_d  = '0;
            unit_cnt_d = '0;
            tone_cnt_d = '0;
            gap_cnt_d  = '0;
            tone_d     = 1'b1;
        end

        if (to_idle) begin
            state_d    = IDLE;
            bit_idx_d  = '0;
            unit_cnt_d = '0;
            tone_cnt_d = '0;
            gap_cnt_d  = '0;
            tone_d     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            bit_idx_q  <= '0;
            unit_cnt_q <= '0;
            tone_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tone_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            bit_idx_q  <= bit_idx_d;
            unit_cnt_q <= unit_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
        end
    end

    // Bit select written as a compare loop so the index width need not match the pattern.
    always_comb begin
        pat_bit = 1'b0;
        for (int i = 0; i < PATTERN_W; i++) begin
            if (bit_idx_q == LEN_W'(i)) pat_bit = pat_q[i];
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign bit_idx = bit_idx_q;
    assign beep    = tone_q & pat_bit & (state_q == PLAY);

endmodule

// File: tb/tb_morse_tone_player.sv
// Scoreboard bench for morse_tone_player: a timeline model predicts per-cycle outputs
// for each transaction, and a negedge monitor pops and compares them.
module tb_morse_tone_player;

    localparam int PW    = 8;
    localparam int TD    = 2;
    localparam int UD    = 8;
    localparam int GU    = 2;
    localparam int LW    = $clog2(PW + 1);
    localparam int NEVER = 100000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [PW-1:0] pattern;
    logic [LW-1:0] length;
    logic          repeat_en;
    logic          stop;
    logic          busy;
    logic          done;
    logic [LW-1:0] bit_idx;
    logic          beep;

    morse_tone_player #(
        .PATTERN_W(PW),
        .TONE_DIV (TD),
        .UNIT_DIV (UD),
        .GAP_UNITS(GU)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .length   (length),
        .repeat_en(repeat_en),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .bit_idx  (bit_idx),
        .beep     (beep)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          busy;
        logic          done;
        logic [LW-1:0] idx;
        logic          beep;
        int            cyc;
    } exp_t;

    exp_t exp_arr[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // model state for the transaction being built
    int   m_stop;
    bit   m_killed;
    bit   m_rep;
    int   m_rdrop;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    function automatic bit rep_at(input int c);
        return m_rep && (c < m_rdrop);
    endfunction

    // Append the expected outputs of the next cycle; after an abort everything reads idle.
    function automatic void emit(input bit b, input bit d, input int idx, input bit bp);
        exp_t e;
        e.busy = m_killed ? 1'b0 : b;
        e.done = m_killed ? 1'b0 : d;
        e.idx  = m_killed ? '0 : LW'(idx);
        e.beep = m_killed ? 1'b0 : bp;
        e.cyc  = 0;
        exp_arr.push_back(e);
        if (e.busy && exp_arr.size() == m_stop) m_killed = 1'b1;
    endfunction

    // Timeline of one transaction: play block of eff*UD cycles, optional gap of GU*UD,
    // repeat decided by repeat_en in the last cycle of each block.
    function automatic void build(input logic [PW-1:0] pat, input int len, input bit rep,
                                  input int rdrop, input int s, input int tail);
        int  eff;
        bit  playing;
        exp_arr.delete();
        m_stop   = s;
        m_killed = (s == 0);
        m_rep    = rep;
        m_rdrop  = rdrop;
        eff      = (len > PW) ? PW : len;
        if (eff == 0 || m_killed) begin
            emit(0, 1, 0, 0);
        end else begin
            playing = 1'b1;
            while (playing) begin
                for (int k = 0; k < eff * UD; k++) begin
                    emit(1, 0, k / UD, pat[3'(k / UD)] && ((k / TD) % 2 == 0));
                    if (m_killed) break;
                end
                if (m_killed) break;
                if (!rep_at(exp_arr.size())) begin
                    emit(0, 1, 0, 0);
                    playing = 1'b0;
                end else if (GU > 0) begin
                    for (int k = 0; k < GU * UD; k++) begin
                        emit(1, 0, 0, 0);
                        if (m_killed) break;
                    end
                    if (m_killed) break;
                    if (!rep_at(exp_arr.size())) begin
                        emit(0, 1, 0, 0);
                        playing = 1'b0;
                    end
                end
            end
        end
        for (int k = 0; k < tail; k++) emit(0, 0, 0, 0);
    endfunction

    // Issue one transaction: start in cycle 0, then per-cycle stop / repeat_en / stray start.
    task automatic run(input logic [PW-1:0] pat, input int len, input bit rep, input int rdrop,
                       input int s, input int x, input int tail);
        int c0;
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        c0 = cyc_cnt;
        build(pat, len, rep, rdrop, s, tail);
        n = exp_arr.size();
        for (int i = 0; i < n; i++) begin
            e     = exp_arr[i];
            e.cyc = c0 + 1 + i;
            sb_q.push_back(e);
        end
        start     = 1'b1;
        pattern   = pat;
        length    = LW'(len);
        repeat_en = rep && (rdrop > 0);
        stop      = (s == 0);
        for (int t = 1; t < n; t++) begin
            @(posedge clk);
            #1;
            start     = (t == x) && exp_arr[t-1].busy;
            pattern   = PW'($urandom);
            length    = LW'($urandom);
            repeat_en = rep && (t < rdrop);
            stop      = (t == s);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc_cnt) begin
            mon_e = sb_q.pop_front();
            check($sformatf("cycle %0d {busy,done,bit_idx,beep}", mon_e.cyc),
                  32'({busy, done, bit_idx, beep}),
                  32'({mon_e.busy, mon_e.done, mon_e.idx, mon_e.beep}));
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pattern   = '0;
        length    = '0;
        repeat_en = 1'b0;
        stop      = 1'b0;
        #1 rst = 1'b0;
        #1 check("reset outputs", 32'({busy, done, bit_idx, beep}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle after reset", 32'({busy, done, bit_idx, beep}), 32'd0);

        run(8'b0000_0101, 3, 1'b0, 0, NEVER, 0, 2);    // single play
        run(8'h5A, 0, 1'b0, 0, NEVER, 0, 2);           // zero length
        run(8'hC3, 15, 1'b0, 0, NEVER, 0, 2);          // length clamped to 8
        run(8'h01, 1, 1'b1, 40, NEVER, 0, 2);          // repeat, drop in second gap
        run(8'hFF, 8, 1'b0, 0, 12, 0, 1);              // abort mid unit 1
        run(8'hA5, 2, 1'b0, 0, NEVER, 0, 2);           // start right after abort
        run(8'b0000_0101, 3, 1'b0, 0, NEVER, 5, 2);    // stray start while busy
        run(8'hFF, 4, 1'b0, 0, 0, 0, 3);               // start with stop in idle

        for (int r = 0; r < 25; r++) begin
            bit rep;
            int s;
            rep = ($urandom_range(0, 2) == 0);
            s   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : NEVER;
            run(PW'($urandom), int'($urandom_range(0, 12)), rep, int'($urandom_range(1, 100)),
                s, int'($urandom_range(1, 30)), int'($urandom_range(1, 3)));
        end

        for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(posedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset in the middle of a unit.
        @(posedge clk);
        #1;
        start     = 1'b1;
        pattern   = 8'hFF;
        length    = LW'(8);
        repeat_en = 1'b0;
        stop      = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("busy before async reset", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1 check("outputs during async reset", 32'({busy, done, bit_idx, beep}), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("idle after async reset %0d", i),
                  32'({busy, done, bit_idx, beep}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
